// File: rtl/anita3_trig_pkg.sv
// Shared widths and entry layout for the ANITA-3 trigger event buffer.
package anita3_trig_pkg;

    localparam int unsigned NUM_PHI_DEF = 16;
    localparam int unsigned TS_W_DEF    = 32;
    localparam int unsigned PHI_W       = 2 * NUM_PHI_DEF;
    localparam int unsigned EVNUM_W     = 16;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned ENTRY_W     = CNT_W + EVNUM_W + TS_W_DEF + PHI_W;

    // Entry layout at default widths, MSB first: {count, evnum, time, phi}.
    typedef struct packed {
        logic [CNT_W-1:0]    count;
        logic [EVNUM_W-1:0]  evnum;
        logic [TS_W_DEF-1:0] stamp;
        logic [PHI_W-1:0]    phi;
    } entry_t;

    // Packed entry width for an arbitrary phi/timestamp build.
    function automatic int unsigned entry_width(int unsigned phi_w, int unsigned ts_w);
        return CNT_W + EVNUM_W + ts_w + phi_w;
    endfunction

endpackage

// File: rtl/anita3_event_fifo.sv
// Single-clock show-ahead FIFO. Head data is combinational from storage while
// non-empty; while empty the last popped word is held on the output.
module anita3_event_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8  // power of 2, at least 2
) (
    input  logic                     clk250_i,
    input  logic                     rst_i,
    input  logic                     wr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     rd_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   fill_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   FILL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FILL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      fill_q, fill_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             valid, full, pop, push;

    // Handshake decode and next-state for pointers, fill and held head word.
    always_comb begin
        valid    = (fill_q != '0);
        full     = (fill_q == FILL_FULL);
        pop      = rd_i & valid;
        // A pop frees the slot being written, so full+pop still accepts.
        push     = wr_i & (~full | pop);
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        last_d   = pop  ? mem_q[rd_ptr_q] : last_q;
        fill_d   = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + FILL_ONE;
        end else if (pop && !push) begin
            fill_d = fill_q - FILL_ONE;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk250_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            last_q   <= last_d;
        end
    end

    // Storage array; contents are only observed when qualified by fill.
    always_ff @(posedge clk250_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Output decode.
    always_comb begin
        rdata_o = valid ? mem_q[rd_ptr_q] : last_q;
        valid_o = valid;
        full_o  = full;
        fill_o  = fill_q;
    end

endmodule

// File: rtl/anita3_trigger_event_buffer.sv
// Trigger event buffer: timestamps and numbers each trigger rising edge and
// queues {count, evnum, time, phi} for downstream readout.
module anita3_trigger_event_buffer
    import anita3_trig_pkg::*;
#(
    parameter int unsigned NUM_PHI  = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TS_WIDTH = 32
) (
    input  logic                       clk250_i,
    input  logic                       rst_i,
    input  logic                       trig_i,
    input  logic [2*NUM_PHI-1:0]       phi_i,
    input  logic [CNT_W-1:0]           count_i,
    input  logic                       rd_i,
    input  logic                       clear_i,
    output logic                       event_valid_o,
    output logic [2*NUM_PHI-1:0]       event_phi_o,
    output logic [TS_WIDTH-1:0]        event_time_o,
    output logic [EVNUM_W-1:0]         event_num_o,
    output logic [CNT_W-1:0]           event_count_o,
    output logic [$clog2(DEPTH):0]     fill_o,
    output logic                       full_o,
    output logic [15:0]                dropped_o,
    output logic                       overflow_o
);

    localparam int unsigned PW = 2 * NUM_PHI;
    localparam int unsigned EW = entry_width(PW, TS_WIDTH);
    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic                trig_q, trig_d;
    logic [EVNUM_W-1:0]  evnum_q, evnum_d;
    logic [15:0]         dropped_q, dropped_d;
    logic                overflow_q, overflow_d;

    logic                wr, pop, drop;
    logic [EW-1:0]       wdata, rdata;
    logic                fifo_valid, fifo_full;

    // Edge detect, numbering and drop accounting.
    always_comb begin
        wr         = trig_i & ~trig_q;
        pop        = rd_i & fifo_valid;
        drop       = wr & fifo_full & ~pop;
        ts_d       = ts_q + TS_WIDTH'(1);
        trig_d     = trig_i;
        // Dropped events still consume a number so readout can see gaps.
        evnum_d    = wr ? evnum_q + EVNUM_W'(1) : evnum_q;
        dropped_d  = dropped_q;
        overflow_d = overflow_q;
        if (clear_i) begin
            dropped_d  = '0;
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (dropped_q != DROP_MAX) begin
                dropped_d = dropped_q + 16'd1;
            end
        end
        wdata      = {count_i, evnum_q, ts_q, phi_i};
    end

    // Top-level state with asynchronous reset.
    always_ff @(posedge clk250_i or posedge rst_i) begin
        if (rst_i) begin
            ts_q       <= '0;
            trig_q     <= 1'b0;
            evnum_q    <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            trig_q     <= trig_d;
            evnum_q    <= evnum_d;
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
        end
    end

    anita3_event_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk250_i (clk250_i),
        .rst_i    (rst_i),
        .wr_i     (wr),
        .wdata_i  (wdata),
        .rd_i     (rd_i),
        .rdata_o  (rdata),
        .valid_o  (fifo_valid),
        .full_o   (fifo_full),
        .fill_o   (fill_o)
    );

    // Unpack the head entry and drive status outputs.
    always_comb begin
        event_valid_o = fifo_valid;
        event_phi_o   = rdata[PW-1:0];
        event_time_o  = rdata[PW +: TS_WIDTH];
        event_num_o   = rdata[PW+TS_WIDTH +: EVNUM_W];
        event_count_o = rdata[EW-1 -: CNT_W];
        full_o        = fifo_full;
        dropped_o     = dropped_q;
        overflow_o    = overflow_q;
    end

endmodule

// File: tb/tb_anita3_trigger_event_buffer.sv
// Bench for the trigger event buffer: directed scenarios plus random traffic,
// checked every cycle against a queue-based event model. A second instance
// with an 8-bit timestamp shares all inputs to exercise timestamp wrap.
module tb_anita3_trigger_event_buffer;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trig = 1'b0;
    logic [31:0] phi = '0;
    logic [7:0]  cnt = '0;
    logic        rd = 1'b0;
    logic        clr = 1'b0;

    logic        valid, full, ovf;
    logic [31:0] ev_phi, ev_time;
    logic [15:0] ev_num, dropped;
    logic [7:0]  ev_cnt;
    logic [3:0]  fill;

    logic        valid8, full8, ovf8;
    logic [31:0] ev_phi8;
    logic [7:0]  ev_time8, ev_cnt8;
    logic [15:0] ev_num8, dropped8;
    logic [3:0]  fill8;

    anita3_trigger_event_buffer #(
        .NUM_PHI (16), .DEPTH (DEPTH), .TS_WIDTH (32)
    ) dut (
        .clk250_i (clk), .rst_i (rst), .trig_i (trig), .phi_i (phi),
        .count_i (cnt), .rd_i (rd), .clear_i (clr),
        .event_valid_o (valid), .event_phi_o (ev_phi), .event_time_o (ev_time),
        .event_num_o (ev_num), .event_count_o (ev_cnt), .fill_o (fill),
        .full_o (full), .dropped_o (dropped), .overflow_o (ovf)
    );

    anita3_trigger_event_buffer #(
        .NUM_PHI (16), .DEPTH (DEPTH), .TS_WIDTH (8)
    ) dut8 (
        .clk250_i (clk), .rst_i (rst), .trig_i (trig), .phi_i (phi),
        .count_i (cnt), .rd_i (rd), .clear_i (clr),
        .event_valid_o (valid8), .event_phi_o (ev_phi8), .event_time_o (ev_time8),
        .event_num_o (ev_num8), .event_count_o (ev_cnt8), .fill_o (fill8),
        .full_o (full8), .dropped_o (dropped8), .overflow_o (ovf8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] phi;
        logic [31:0] ts;
        logic [15:0] num;
        logic [7:0]  cnt;
    } ev_t;

    ev_t         q_m[$];
    ev_t         last_m;
    logic [31:0] ts_m;
    logic        prev_m;
    logic [15:0] num_m, drop_m;
    logic        ovf_m;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        last_m = '{phi: '0, ts: '0, num: '0, cnt: '0};
        ts_m   = '0;
        prev_m = 1'b0;
        num_m  = '0;
        drop_m = '0;
        ovf_m  = 1'b0;
    endtask

    task automatic check_all();
        ev_t h;
        if (q_m.size() > 0) h = q_m[0];
        else                h = last_m;
        check_eq("valid",    valid,   q_m.size() != 0);
        check_eq("fill",     fill,    q_m.size());
        check_eq("full",     full,    q_m.size() == DEPTH);
        check_eq("dropped",  dropped, drop_m);
        check_eq("overflow", ovf,     ovf_m);
        check_eq("phi",      ev_phi,  h.phi);
        check_eq("time",     ev_time, h.ts);
        check_eq("num",      ev_num,  h.num);
        check_eq("count",    ev_cnt,  h.cnt);
        check_eq("valid8",   valid8,  q_m.size() != 0);
        check_eq("fill8",    fill8,   q_m.size());
        check_eq("full8",    full8,   q_m.size() == DEPTH);
        check_eq("dropped8", dropped8, drop_m);
        check_eq("ovf8",     ovf8,    ovf_m);
        check_eq("phi8",     ev_phi8, h.phi);
        check_eq("time8",    ev_time8, h.ts[7:0]);
        check_eq("num8",     ev_num8, h.num);
        check_eq("count8",   ev_cnt8, h.cnt);
    endtask

    // Called at a falling edge: drive, check current state, advance model.
    task automatic step(input logic t, input logic [31:0] p, input logic [7:0] c,
                        input logic r, input logic cl);
        logic wr_m, pop_m, drp;
        int   n;
        trig = t; phi = p; cnt = c; rd = r; clr = cl;
        check_all();
        n     = q_m.size();
        wr_m  = t && !prev_m;
        pop_m = r && (n > 0);
        drp   = 1'b0;
        if (pop_m) last_m = q_m.pop_front();
        if (wr_m) begin
            if (n < DEPTH || pop_m) q_m.push_back('{phi: p, ts: ts_m, num: num_m, cnt: c});
            else                    drp = 1'b1;
            num_m = num_m + 16'd1;
        end
        if (cl) begin
            drop_m = '0;
            ovf_m  = 1'b0;
        end else if (drp) begin
            ovf_m = 1'b1;
            if (drop_m != 16'hFFFF) drop_m = drop_m + 16'd1;
        end
        ts_m   = ts_m + 32'd1;
        prev_m = t;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    // Assert reset between edges, check the immediate effect, release at a falling edge.
    task automatic async_reset();
        trig = 1'b0; rd = 1'b0; clr = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_fill",  fill,  4'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single pulse at cycle 10.
        idle(10);
        step(1'b1, 32'h0003_0000, 8'h05, 1'b0, 1'b0);
        check_eq("first_time",  ev_time, 32'd10);
        check_eq("first_num",   ev_num,  16'd0);
        check_eq("first_phi",   ev_phi,  32'h0003_0000);
        check_eq("first_count", ev_cnt,  8'h05);
        check_eq("first_fill",  fill,    4'd1);
        drain(1);

        // Four-cycle pulse then a single pulse 20 cycles after the first rise.
        for (int i = 0; i < 4; i++) step(1'b1, 32'hA5A5_0001, 8'h11, 1'b0, 1'b0);
        idle(16);
        step(1'b1, 32'h0000_8000, 8'h22, 1'b0, 1'b0);
        idle(1);
        check_eq("two_fill", fill, 4'd2);
        drain(3);

        // Ten edges with no reads: two drops.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0);
            step(1'b0, '0, '0, 1'b0, 1'b0);
        end
        check_eq("ovf_fill",    fill,    4'd8);
        check_eq("ovf_full",    full,    1'b1);
        check_eq("ovf_dropped", dropped, 16'd2);
        check_eq("ovf_flag",    ovf,     1'b1);
        // Write and pop together while full.
        step(1'b1, 32'hDEAD_BEEF, 8'h77, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check_eq("wrrd_fill",    fill,    4'd8);
        check_eq("wrrd_dropped", dropped, 16'd2);
        // Clear in the same cycle as a drop.
        step(1'b1, 32'h1234_5678, 8'h33, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check_eq("clr_dropped", dropped, 16'd0);
        check_eq("clr_ovf",     ovf,     1'b0);
        drain(9);
        // Reads while empty.
        drain(3);
        check_eq("empty_fill", fill, 4'd0);

        // Random traffic: a read-heavy phase then a write-heavy phase.
        for (int i = 0; i < 1000; i++)
            step($urandom_range(0, 9) < 3, $urandom, 8'($urandom),
                 $urandom_range(0, 9) < 5, $urandom_range(0, 49) == 0);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 9) < 4, $urandom, 8'($urandom),
                 $urandom_range(0, 9) < 1, $urandom_range(0, 99) == 0);
        drain(10);

        // Asynchronous reset with three entries stored.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0);
            step(1'b0, '0, '0, 1'b0, 1'b0);
        end
        check_eq("pre_rst_fill", fill, 4'd3);
        async_reset();
        idle(3);
        step(1'b1, 32'h0F0F_0F0F, 8'h9C, 1'b0, 1'b0);
        check_eq("post_rst_num",  ev_num, 16'd0);
        check_eq("post_rst_time", ev_time, 32'd3);
        drain(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
